uart_upg_loader: RTL and testbench
==================================

# uart_upg_loader

UART programming loader: the initiator side of the UPG write interface consumed by the instruction and data RAM wrappers. It receives an 8N1 byte stream on `rx_i`, parses a tagged section format, assembles little-endian 32-bit words, and drives `upg_wen_o`/`upg_adr_o`/`upg_dat_o`. On receiving the end tag it raises `upg_done_o`, which hands memory ports back to the CPU. Runs entirely in the UPG clock domain.

## Interface
- `CLKS_PER_BIT`, 87, UPG clock cycles per UART bit (10 MHz / 115200); must be ≥ 4.
- `MAX_WORDS`, 16384, largest legal word count per section; one memory's word depth.

- `upg_clk_i` in 1: the single clock, 10 MHz UPG clock.
- `upg_rst_i` in 1: reset, synchronous, active-high.
- `rx_i` in 1: asynchronous UART line, idle high.
- `upg_wen_o` out 1: one-cycle write strobe.
- `upg_adr_o` out 15: bit 14 = 0 for instruction RAM, 1 for data RAM; bits 13:0 = word index.
- `upg_dat_o` out 32: write data.
- `upg_done_o` out 1: load complete; sticky until reset.
- `err_o` out 1: sticky protocol or framing error.

## Operation
- Stream format: repeated sections, each `TAG`, `CNT_LO`, `CNT_HI`, then `4*CNT` data bytes (word byte 0 first, LSB-first). `TAG` 0x00 selects instruction RAM; 0x01 selects data RAM; 0xFF ends the load (no count follows).
- Parser states: `S_TAG` → `S_CNT_LO` → `S_CNT_HI` → `S_DATA` → `S_TAG`; `S_TAG` also goes to `S_DONE` on 0xFF or to `S_ERR` on any other unknown tag.
- In `S_CNT_HI`:
  - A count of 0 goes directly to `S_TAG`.
  - A count greater than `MAX_WORDS` goes to `S_ERR`.
  - Otherwise the word index clears to 0 and the parser enters `S_DATA` with byte lane 0.
- In `S_DATA`:
  - Each byte fills lane 0..3 in turn.
  - On lane 3, the strobe fires with `adr = {sel, index}` and `dat = {b3,b2,b1,b0}`.
  - Then the index increments and the remaining count decrements.
  - When the count reaches 0, the parser returns to `S_TAG`.
- Each section restarts its index at 0. A repeated section for the same memory overwrites from word 0.
- `S_DONE`: `upg_done_o=1`; all further bytes are ignored; no more strobes.
- `S_ERR`: `err_o=1`; `upg_done_o` stays 0; the block waits for reset; bytes are ignored.
- Framing error (stop bit sampled 0): the byte is discarded, `err_o=1`, and the parser goes to `S_ERR`.

## Timing
- Reset values: `upg_wen_o=0`, `upg_adr_o=0`, `upg_dat_o=0`, `upg_done_o=0`, `err_o=0`. Parser state is `S_TAG`, count and index are 0, and the RX sub-block is idle.
- RX path:
  - `rx_i` passes through a 2-flop synchronizer, reset value 1.
  - A start bit is a falling edge seen while idle.
  - It is re-checked low at `CLKS_PER_BIT/2`; if high it is a glitch and the receiver returns to idle.
  - Data bits are sampled every `CLKS_PER_BIT` after that point, LSB first, followed by the stop bit.
- Byte valid: the receiver issues a one-cycle `byte_valid` pulse in the cycle after the stop-bit sample. The parser consumes it the same cycle.
- Write strobe: `upg_wen_o` pulses high for exactly one cycle, one cycle after the lane-3 `byte_valid`. `upg_adr_o` and `upg_dat_o` are valid in that cycle and held until the next strobe.
- Done: `upg_done_o` rises one cycle after the 0xFF `byte_valid`.
- Back-to-back bytes, with the stop bit followed immediately by the next start bit, must be accepted without loss.
- Reset mid-byte or mid-section: the current byte and the partial word are abandoned, no strobe is issued, and outputs return to reset values on the next edge.
- Counter widths: count is 15 bits, index is 14 bits, and the index never wraps because count ≤ `MAX_WORDS`.

## Structure
- Package `upg_pkg`: parser state enum, tag constants (`TAG_IMEM=8'h00`, `TAG_DMEM=8'h01`, `TAG_END=8'hFF`), default `CLKS_PER_BIT`.
- Sub-module `uart_rx_8n1` (parameter `CLKS_PER_BIT`; ports `upg_clk_i`, `upg_rst_i`, `rx_i`, `byte_o[7:0]`, `byte_valid_o`, `frame_err_o`) contains the synchronizer, bit timer and shift register. The top level holds the parser and word assembler.

## Test plan
- Send 00 02 00 | 78 56 34 12 | EF BE AD DE | FF: two strobes, adr 0x0000/dat 0x12345678, then adr 0x0001/dat 0xDEADBEEF; `upg_done_o=1`; `err_o=0`.
- Send 01 01 00 | 01 00 00 00 | FF: one strobe with adr 0x4000, dat 0x00000001.
- Send 00 00 00 | FF: no strobes; done asserts.
- Send tag 0x42, and separately a count of 0x4001: `err_o=1`, no strobe, done stays 0; later bytes are ignored.
- Send a byte with stop bit 0, and separately a 0.3-bit low glitch on `rx_i`: framing error gives `err_o=1`; the glitch produces no byte and no error.
- Assert `upg_rst_i` after 2 of 4 data bytes, then send a full 00 01 00 AA BB CC DD FF: one strobe with adr 0, dat 0xDDCCBBAA; no stale bytes are merged.

Source files
------------

// File: rtl/uart_upg_loader_pkg.sv
// Shared types and constants for the UART programming loader.
// Parser/receiver state encodings, section tags and parameter defaults.
package upg_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int DEFAULT_MAX_WORDS    = 16384;

  localparam logic [7:0] TAG_IMEM = 8'h00;
  localparam logic [7:0] TAG_DMEM = 8'h01;
  localparam logic [7:0] TAG_END  = 8'hFF;

  typedef enum logic [2:0] {
    S_TAG,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_DONE,
    S_ERR
  } upg_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Only the two memory-select tags open a counted section.
  function automatic logic is_mem_tag(input logic [7:0] tag);
    return (tag == TAG_IMEM) || (tag == TAG_DMEM);
  endfunction

endpackage

// File: rtl/uart_upg_loader_if.sv
// UPG write port: strobe/address/data toward the RAM wrappers plus load status.
// The loader drives it (master); RAM wrappers and the CPU handover logic observe it (slave).
interface uart_upg_loader_if;

  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        err_o;

  modport master (
    output upg_wen_o,
    output upg_adr_o,
    output upg_dat_o,
    output upg_done_o,
    output err_o
  );

  modport slave (
    input upg_wen_o,
    input upg_adr_o,
    input upg_dat_o,
    input upg_done_o,
    input err_o
  );

endinterface

// File: rtl/uart_upg_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start check.
// byte_valid_o / frame_err_o pulse one cycle after the stop-bit sample; no backpressure.
module uart_rx_8n1
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       upg_clk_i,
  input  logic       upg_rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_byte;
  logic            r_valid;
  logic            r_ferr;

  assign byte_o       = r_byte;
  assign byte_valid_o = r_valid;
  assign frame_err_o  = r_ferr;

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_prev    <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (r_cnt == HALF_M1) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          // Returning to idle at mid-stop lets a back-to-back start edge be seen.
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync2) begin
              r_byte  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_upg_loader.sv
// UART programming loader: parses TAG/CNT/data sections into 32-bit UPG word writes.
// Strobe one cycle after the lane-3 byte; no backpressure, the RAM port always accepts.
module uart_upg_loader
  import upg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MAX_WORDS    = DEFAULT_MAX_WORDS
) (
  input  logic               upg_clk_i,
  input  logic               upg_rst_i,
  input  logic               rx_i,
  uart_upg_loader_if.master  upg
);

  localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

  logic [7:0]  w_byte;
  logic        w_byte_vld;
  logic        w_frame_err;
  logic [15:0] w_cnt;

  upg_state_t  r_state;
  logic [7:0]  r_cnt_lo;
  logic [14:0] r_count;
  logic [13:0] r_index;
  logic [1:0]  r_lane;
  logic        r_sel;
  logic [23:0] r_buf;
  logic        r_wen;
  logic [14:0] r_adr;
  logic [31:0] r_dat;
  logic        r_done;
  logic        r_err;

  uart_rx_8n1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .upg_clk_i    (upg_clk_i),
    .upg_rst_i    (upg_rst_i),
    .rx_i         (rx_i),
    .byte_o       (w_byte),
    .byte_valid_o (w_byte_vld),
    .frame_err_o  (w_frame_err)
  );

  assign w_cnt = {w_byte, r_cnt_lo};

  assign upg.upg_wen_o  = r_wen;
  assign upg.upg_adr_o  = r_adr;
  assign upg.upg_dat_o  = r_dat;
  assign upg.upg_done_o = r_done;
  assign upg.err_o      = r_err;

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      r_state  <= S_TAG;
      r_cnt_lo <= '0;
      r_count  <= '0;
      r_index  <= '0;
      r_lane   <= '0;
      r_sel    <= 1'b0;
      r_buf    <= '0;
      r_wen    <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      // Once done or failed the loader is deaf until reset, framing errors included.
      if (w_frame_err && (r_state != S_DONE) && (r_state != S_ERR)) begin
        r_state <= S_ERR;
        r_err   <= 1'b1;
      end else if (w_byte_vld) begin
        case (r_state)
          S_TAG: begin
            if (w_byte == TAG_END) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (is_mem_tag(w_byte)) begin
              r_sel   <= w_byte[0];
              r_state <= S_CNT_LO;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          S_CNT_LO: begin
            r_cnt_lo <= w_byte;
            r_state  <= S_CNT_HI;
          end
          S_CNT_HI: begin
            if (w_cnt == 16'd0) begin
              r_state <= S_TAG;
            end else if ({1'b0, w_cnt} > MAX_CNT) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_count <= w_cnt[14:0];
              r_index <= '0;
              r_lane  <= '0;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            case (r_lane)
              2'd0: r_buf[7:0]   <= w_byte;
              2'd1: r_buf[15:8]  <= w_byte;
              2'd2: r_buf[23:16] <= w_byte;
              default: begin
                r_wen   <= 1'b1;
                r_adr   <= {r_sel, r_index};
                r_dat   <= {w_byte, r_buf};
                r_index <= r_index + 14'd1;
                r_count <= r_count - 15'd1;
                if (r_count == 15'd1) begin
                  r_state <= S_TAG;
                end
              end
            endcase
            r_lane <= r_lane + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_upg_loader.sv
// Randomized and directed byte streams against a section-walking reference of the load format.
module tb_uart_upg_loader;
  import upg_pkg::*;

  localparam int C    = 8;
  localparam int MAXW = 16384;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  always #5 clk = ~clk;

  uart_upg_loader_if u_if ();

  uart_upg_loader #(
    .CLKS_PER_BIT (C),
    .MAX_WORDS    (MAXW)
  ) dut (
    .upg_clk_i (clk),
    .upg_rst_i (rst),
    .rx_i      (rx),
    .upg       (u_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [8:0]  stim_q[$];
  logic [46:0] act_q[$];
  logic [46:0] exp_q[$];
  bit          exp_done;
  bit          exp_err;
  int          double_wen;
  logic        prev_wen = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (u_if.upg_wen_o) act_q.push_back({u_if.upg_adr_o, u_if.upg_dat_o});
    if (u_if.upg_wen_o && prev_wen) double_wen++;
    prev_wen = u_if.upg_wen_o;
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit 8 set means the stop bit is sent as 0.
  task automatic send_byte(input logic [8:0] b);
    rx = 1'b0;
    ticks(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(C);
    end
    rx = ~b[8];
    ticks(C);
    rx = 1'b1;
    if (b[8]) ticks(2 * C);
  endtask

  task automatic send_stream(input int max_gap);
    foreach (stim_q[i]) begin
      send_byte(stim_q[i]);
      ticks($urandom_range(0, max_gap));
    end
  endtask

  task automatic push_bytes(input logic [7:0] b[$]);
    foreach (b[i]) stim_q.push_back({1'b0, b[i]});
  endtask

  // Walk the stream section by section; a bad stop bit truncates it and is an error
  // unless the load had already finished or failed.
  task automatic model_run();
    int n, k, i, cnt, base;
    bit fin;
    logic [7:0] tag;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    fin = 0;
    n = stim_q.size();
    k = n;
    for (int j = n - 1; j >= 0; j--) if (stim_q[j][8]) k = j;
    i = 0;
    while (!fin && i < k) begin
      tag = stim_q[i][7:0];
      if (tag == 8'hFF) begin
        exp_done = 1;
        fin = 1;
      end else if (tag > 8'h01) begin
        exp_err = 1;
        fin = 1;
      end else if (i + 2 >= k) begin
        i = k;
      end else begin
        cnt = int'(stim_q[i+1][7:0]) + 256 * int'(stim_q[i+2][7:0]);
        if (cnt > MAXW) begin
          exp_err = 1;
          fin = 1;
        end else begin
          for (int w = 0; w < cnt; w++) begin
            base = i + 3 + 4 * w;
            if (base + 3 < k)
              exp_q.push_back({tag[0], 14'(w), stim_q[base+3][7:0], stim_q[base+2][7:0],
                               stim_q[base+1][7:0], stim_q[base][7:0]});
          end
          i = i + 3 + 4 * cnt;
        end
      end
    end
    if (!fin && k < n) exp_err = 1;
  endtask

  task automatic do_reset(input string name);
    rx  = 1'b1;
    rst = 1'b1;
    ticks(3);
    check_eq({name, "_reset"}, {u_if.upg_wen_o, u_if.upg_adr_o, u_if.upg_dat_o,
                                u_if.upg_done_o, u_if.err_o}, 64'd0);
    rst = 1'b0;
    ticks(2);
    act_q.delete();
    double_wen = 0;
  endtask

  task automatic compare(input string name);
    int m;
    model_run();
    check_eq({name, "_nwrites"}, 64'(act_q.size()), 64'(exp_q.size()));
    m = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check_eq({name, "_write"}, 64'(act_q[i]), 64'(exp_q[i]));
    check_eq({name, "_done"}, 64'(u_if.upg_done_o), 64'(exp_done));
    check_eq({name, "_err"}, 64'(u_if.err_o), 64'(exp_err));
    check_eq({name, "_wen_width"}, 64'(double_wen), 64'd0);
    if (exp_q.size() > 0)
      check_eq({name, "_hold"}, 64'({u_if.upg_adr_o, u_if.upg_dat_o}), 64'(exp_q[$]));
  endtask

  task automatic run_stream(input string name, input int max_gap);
    do_reset(name);
    send_stream(max_gap);
    ticks(3 * C);
    compare(name);
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    double_wen = 0;

    stim_q.delete();
    push_bytes('{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF});
    run_stream("imem2", 0);

    stim_q.delete();
    push_bytes('{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF});
    run_stream("dmem1", 5);

    stim_q.delete();
    push_bytes('{8'h00, 8'h00, 8'h00, 8'hFF});
    run_stream("zero_cnt", 3);

    stim_q.delete();
    push_bytes('{8'h42, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF});
    run_stream("bad_tag", 2);

    stim_q.delete();
    push_bytes('{8'h00, 8'h01, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF});
    run_stream("cnt_4001", 2);

    stim_q.delete();
    push_bytes('{8'h01, 8'h00, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88});
    run_stream("cnt_4000", 0);

    stim_q.delete();
    push_bytes('{8'h00, 8'h01, 8'h00, 8'h10});
    stim_q.push_back(9'h120);
    push_bytes('{8'h30, 8'h40, 8'hFF});
    run_stream("frame_err", 1);

    stim_q.delete();
    push_bytes('{8'hFF, 8'h00, 8'h01, 8'h00, 8'h99, 8'h98, 8'h97, 8'h96});
    run_stream("after_done", 0);

    // Glitch shorter than half a bit must not start a byte.
    do_reset("glitch");
    rx = 1'b0;
    ticks(3);
    rx = 1'b1;
    ticks(2 * C);
    check_eq("glitch_no_err", 64'(u_if.err_o), 64'd0);
    check_eq("glitch_no_write", 64'(act_q.size()), 64'd0);
    stim_q.delete();
    push_bytes('{8'h00, 8'h00, 8'h00, 8'hFF});
    send_stream(0);
    ticks(3 * C);
    compare("glitch");

    // Reset in the middle of a word, after a completed write made the outputs non-zero.
    do_reset("midrst");
    stim_q.delete();
    push_bytes('{8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB});
    send_stream(0);
    ticks(C);
    check_eq("midrst_pre", 64'(u_if.upg_adr_o), 64'h4000);
    rst = 1'b1;
    ticks(1);
    check_eq("midrst_outs", {u_if.upg_wen_o, u_if.upg_adr_o, u_if.upg_dat_o,
                             u_if.upg_done_o, u_if.err_o}, 64'd0);
    rst = 1'b0;
    ticks(2);
    act_q.delete();
    double_wen = 0;
    stim_q.delete();
    push_bytes('{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF});
    send_stream(0);
    ticks(3 * C);
    compare("midrst");
    check_eq("midrst_dat", 64'(u_if.upg_dat_o), 64'hDDCCBBAA);

    for (int t = 0; t < 12; t++) begin
      int nsec;
      stim_q.delete();
      nsec = $urandom_range(1, 3);
      for (int s = 0; s < nsec; s++) begin
        int cnt;
        if ($urandom_range(0, 9) == 0) stim_q.push_back({1'b0, 8'($urandom_range(2, 254))});
        else stim_q.push_back({1'b0, 8'($urandom_range(0, 1))});
        cnt = $urandom_range(0, 3);
        stim_q.push_back({1'b0, 8'(cnt)});
        stim_q.push_back(9'h000);
        for (int b = 0; b < 4 * cnt; b++) stim_q.push_back({1'b0, 8'($urandom_range(0, 255))});
      end
      if ($urandom_range(0, 3) != 0) begin
        stim_q.push_back(9'h0FF);
        push_bytes('{8'h00, 8'h01, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3});
      end
      if ($urandom_range(0, 4) == 0)
        stim_q[$urandom_range(0, stim_q.size() - 1)][8] = 1'b1;
      run_stream($sformatf("rand%0d", t), ($urandom_range(0, 1) == 1) ? 0 : 2 * C);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
